// File: rtl/mem_bus_unit.sv
// Memory-side datapath stage: MAR/MDR holding registers, req/ack memory port
// sequencing for MemRd/MemWr strobes, and read-data return onto the internal bus.
module mem_bus_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              MARWr,
  input  logic              MDRWr,
  input  logic              MDRSrc,
  input  logic              MDROe,
  input  logic              MemOe,
  input  logic              MemRd,
  input  logic              MemWr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      rd_buf_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      rd_buf_q    <= rd_buf_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mar_d       = MARWr ? ADDR_W'(bus_in) : mar_q;
    mdr_d       = MDRWr ? (MDRSrc ? rd_buf_q : bus_in) : mdr_q;
    rd_buf_d    = rd_buf_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_req_d   = mem_req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Transaction latches pre-edge MAR/MDR; a simultaneous conflict is flagged and run as a read.
        if (MemRd || MemWr) begin
          mem_addr_d  = mar_q;
          mem_wdata_d = mdr_q;
          mem_we_d    = MemWr & ~MemRd;
          err_d       = err_q | (MemRd & MemWr);
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!mem_we_q) rd_buf_d = mem_rdata;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_out   = MDROe ? mdr_q : rd_buf_q;
  assign bus_oe    = MDROe | MemOe;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_req   = mem_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit; the bench plays the memory and keeps a
// scoreboard of expected transaction attributes captured at strobe time.
module tb_mem_bus_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        bus_oe;
  logic        MARWr, MDRWr, MDRSrc, MDROe, MemOe, MemRd, MemWr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_req, mem_ack;
  logic [31:0] mem_rdata;
  logic        busy, done, err;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] m_mar, m_mdr, m_rdbuf;
  logic        m_err;

  mem_bus_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .MARWr(MARWr), .MDRWr(MDRWr), .MDRSrc(MDRSrc), .MDROe(MDROe), .MemOe(MemOe),
    .MemRd(MemRd), .MemWr(MemWr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [31:0] v);
    MARWr = 1'b1; bus_in = v;
    tick();
    MARWr = 1'b0; bus_in = '0;
    m_mar = v;
  endtask

  task automatic load_mdr(input logic [31:0] v, input logic src);
    MDRWr = 1'b1; MDRSrc = src; bus_in = v;
    tick();
    MDRWr = 1'b0; MDRSrc = 1'b0; bus_in = '0;
    m_mdr = src ? m_rdbuf : v;
  endtask

  // Strobe, then ack in REQ cycle n; optionally pokes MemWr during REQ and
  // loads MAR in the strobe cycle.
  task automatic txn(input logic rd, input logic wr, input int unsigned n,
                     input logic [31:0] rdata, input logic poke,
                     input logic mar_upd, input logic [31:0] mar_val);
    exp_t e;
    e.addr  = m_mar;
    e.we    = wr & ~rd;
    e.wdata = m_mdr;
    sb.push_back(e);
    if (rd && wr) m_err = 1'b1;
    MemRd = rd; MemWr = wr;
    if (mar_upd) begin MARWr = 1'b1; bus_in = mar_val; end
    tick();
    MemRd = 1'b0; MemWr = 1'b0; MARWr = 1'b0; bus_in = '0;
    if (mar_upd) m_mar = mar_val;
    e = sb.pop_front();
    chk("req_rise", 32'(mem_req), 32'd1);
    chk("busy_rise", 32'(busy), 32'd1);
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_we", 32'(mem_we), 32'(e.we));
    chk("mem_wdata", mem_wdata, e.wdata);
    MemWr = poke;
    for (int unsigned i = 1; i < n; i++) begin
      tick();
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("busy_hold", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done), 32'd0);
      chk("addr_stable", mem_addr, e.addr);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; MemWr = 1'b0;
    if (!e.we) m_rdbuf = rdata;
    chk("done_pulse", 32'(done), 32'd1);
    chk("req_fall", 32'(mem_req), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("we_retained", 32'(mem_we), 32'(e.we));
    chk("addr_retained", mem_addr, e.addr);
    tick();
    chk("done_end", 32'(done), 32'd0);
    chk("no_second_txn", 32'(mem_req), 32'd0);
    chk("err_flag", 32'(err), 32'(m_err));
  endtask

  initial begin
    int unsigned n;
    logic        saw_done;
    exp_t        e;

    rst_n = 1'b0; bus_in = '0; MARWr = 0; MDRWr = 0; MDRSrc = 0; MDROe = 0; MemOe = 0;
    MemRd = 0; MemWr = 0; mem_ack = 0; mem_rdata = '0;
    m_mar = '0; m_mdr = '0; m_rdbuf = '0; m_err = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_bus_out", bus_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write with ack in the third REQ cycle
    load_mar(32'h0000_0010);
    load_mdr(32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 1'b1, 3, 32'h0, 1'b0, 1'b0, 32'h0);

    // Fastest read, then return data to bus and through MDR
    load_mar(32'h0000_0020);
    txn(1'b1, 1'b0, 1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    MemOe = 1'b1; #1;
    chk("rd_bus_out", bus_out, m_rdbuf);
    chk("rd_bus_oe", 32'(bus_oe), 32'd1);
    MemOe = 1'b0;
    load_mdr(32'hFFFF_FFFF, 1'b1);
    MDROe = 1'b1; #1;
    chk("mdr_from_rdbuf", bus_out, 32'h1234_5678);
    MDROe = 1'b0;

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("idle_ack_done", 32'(done), 32'd0);
    MemOe = 1'b1; #1;
    chk("idle_ack_rdbuf", bus_out, m_rdbuf);
    MemOe = 1'b0;

    // Timeout: never ack
    load_mar(32'h0000_0030);
    e.addr = m_mar; e.we = 1'b0; e.wdata = m_mdr;
    sb.push_back(e);
    MemRd = 1'b1;
    tick();
    MemRd = 1'b0;
    e = sb.pop_front();
    chk("to_addr", mem_addr, e.addr);
    n = 0; saw_done = 1'b0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    m_err = 1'b1;
    chk("to_req_cycles", n, 32'd15);
    chk("to_no_done", 32'(saw_done | done), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    MemOe = 1'b1; #1;
    chk("to_rdbuf_kept", bus_out, m_rdbuf);
    MemOe = 1'b0;
    txn(1'b1, 1'b0, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);

    // Conflict read/write with MemWr poked during REQ; err was already set
    load_mar(32'h0000_0050);
    load_mdr(32'h1111_2222, 1'b0);
    txn(1'b1, 1'b1, 2, 32'h3333_4444, 1'b1, 1'b0, 32'h0);

    // Same-cycle MAR load with MemRd uses the old MAR
    txn(1'b1, 1'b0, 1, 32'h5555_6666, 1'b0, 1'b1, 32'h0000_0040);
    load_mdr(32'h0, 1'b0);
    txn(1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("new_mar_used", mem_addr, 32'h0000_0040);

    // Reset in the second REQ cycle
    load_mar(32'h0000_0060);
    MemRd = 1'b1;
    tick();
    MemRd = 1'b0;
    tick();
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0; #1;
    m_mar = '0; m_mdr = '0; m_rdbuf = '0; m_err = 1'b0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    MemOe = 1'b1; #1;
    chk("mid_rst_rdbuf", bus_out, 32'd0);
    MemOe = 1'b0; MDROe = 1'b1; #1;
    chk("mid_rst_mdr", bus_out, 32'd0);
    MDROe = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 32'(done), 32'd0);
    load_mar(32'h0000_0070);
    txn(1'b1, 1'b0, 2, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    MemOe = 1'b1; #1;
    chk("post_rst_read", bus_out, 32'h0BAD_F00D);
    MemOe = 1'b0;

    // Bus drive priority
    load_mar(32'h0000_0080);
    txn(1'b1, 1'b0, 1, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0);
    load_mdr(32'hA5A5_A5A5, 1'b0);
    MDROe = 1'b1; MemOe = 1'b1; #1;
    chk("prio_both", bus_out, 32'hA5A5_A5A5);
    chk("prio_oe", 32'(bus_oe), 32'd1);
    MDROe = 1'b0; #1;
    chk("prio_memoe", bus_out, 32'h5A5A_5A5A);
    MemOe = 1'b0; #1;
    chk("prio_none_oe", 32'(bus_oe), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
